// File: rtl/duo_ctrl_pkg.sv
// Shared definitions for the two-tone colour generator sequencer.
//   DIV_W    : width of step-period register and prescaler
//   DEF_DIV  : reset value of the period register
//   ST_*     : encodings of the sequencer state output
//   cmd_e    : command decoded from the simultaneous command pulses
package duo_ctrl_pkg;

  localparam int          DIV_W    = 24;
  localparam int unsigned DEF_DIV  = 1_000_000;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_STOP,
    CMD_PAUSE,
    CMD_RUN,
    CMD_STEP
  } cmd_e;

  // Collapse simultaneous command pulses to the single one that takes effect.
  function automatic cmd_e cmd_decode(input logic stop, input logic pause,
                                      input logic run, input logic step);
    cmd_e c;
    if (stop)       c = CMD_STOP;
    else if (pause) c = CMD_PAUSE;
    else if (run)   c = CMD_RUN;
    else if (step)  c = CMD_STEP;
    else            c = CMD_NONE;
    return c;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with last-served pointer.
//   clk, rst_n : clock, async active-low reset
//   req[1:0]   : requests for this cycle (already masked by the caller)
//   gnt[1:0]   : combinational one-hot grant; pointer advances on any grant
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // last_q = 1 means requester 1 was served last; reset so requester 0 wins first.
  logic last_q, last_d;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (gnt != 2'b00) last_d = gnt[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/duo_color_ctrl.sv
// Sequencer and sample arbiter for the shared two-tone colour generator.
// Optional feature macro: DUO_STEP_COUNT_EN (step counter; tied to zero when undefined).
//   clk, rst_n          : clock, async active-low reset
//   cfg_we, cfg_div     : load step period (minus one), clears prescaler
//   cmd_stop/pause/run/step : command pulses, priority stop > pause > run > step
//   duo_in[7:0]         : colour pair from the generator
//   step_en             : one-cycle step enable to the generator
//   req[1:0] / ack[1:0] : consumer sample requests / one-cycle grants
//   sample[7:0]         : duo_in captured for the acked consumer
//   state[1:0]          : IDLE=00, RUN=01, PAUSE=10
//   step_cnt[15:0]      : steps issued (zero without DUO_STEP_COUNT_EN)
//
// state | meaning
// IDLE  | no periodic steps, prescaler cleared; single steps allowed
// RUN   | prescaler counts, one step per period+1 cycles
// PAUSE | prescaler frozen; single steps allowed, resume keeps phase
module duo_color_ctrl #(
  parameter int          DIV_W   = duo_ctrl_pkg::DIV_W,
  parameter int unsigned DEF_DIV = duo_ctrl_pkg::DEF_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cmd_stop,
  input  logic             cmd_pause,
  input  logic             cmd_run,
  input  logic             cmd_step,
  input  logic [7:0]       duo_in,
  output logic             step_en,
  input  logic [1:0]       req,
  output logic [1:0]       ack,
  output logic [7:0]       sample,
  output logic [1:0]       state,
  output logic [15:0]      step_cnt
);

  import duo_ctrl_pkg::*;

  cmd_e             cmd;
  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic             step_en_q, step_en_d;
  logic [1:0]       ack_q;
  logic [1:0]       gnt;
  logic [7:0]       sample_q, sample_d;

  assign cmd = cmd_decode(cmd_stop, cmd_pause, cmd_run, cmd_step);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (cmd)
      CMD_STOP:  state_d = ST_IDLE;
      CMD_PAUSE: if (state_q == ST_RUN) state_d = ST_PAUSE;
      CMD_RUN:   if (state_q != ST_RUN) state_d = ST_RUN;
      default:   state_d = state_q;
    endcase
    if (state_q != ST_IDLE && state_q != ST_RUN && state_q != ST_PAUSE)
      state_d = ST_IDLE;
  end

  // Output / datapath logic: prescaler, period register, step pulse
  always_comb begin
    presc_d   = presc_q;
    period_d  = period_q;
    step_en_d = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        // A pause freezes the count on the very edge it is taken.
        if (cmd != CMD_STOP && cmd != CMD_PAUSE) begin
          if (presc_q >= period_q) begin
            presc_d   = '0;
            step_en_d = 1'b1;
          end else begin
            presc_d = presc_q + DIV_W'(1);
          end
        end
      end
      ST_IDLE: begin
        if (cmd == CMD_RUN)  presc_d   = '0;
        if (cmd == CMD_STEP) step_en_d = 1'b1;
      end
      ST_PAUSE: begin
        if (cmd == CMD_STEP) step_en_d = 1'b1;
      end
      default: presc_d = '0;
    endcase

    if (cmd == CMD_STOP) begin
      presc_d   = '0;
      step_en_d = 1'b0;
    end

    // Reprogramming restarts the period cleanly and suppresses any step on that edge.
    if (cfg_we) begin
      period_d  = cfg_div;
      presc_d   = '0;
      step_en_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      period_q  <= DIV_W'(DEF_DIV);
      step_en_q <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      period_q  <= period_d;
      step_en_q <= step_en_d;
    end
  end

  // A requester whose ack is currently high is masked so a held req is not
  // granted back-to-back; it re-enters arbitration the following cycle.
  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req & ~ack_q),
    .gnt   (gnt)
  );

  // duo_in only moves on the edge after step_en, so this capture is never torn.
  always_comb begin
    sample_d = sample_q;
    if (gnt != 2'b00) sample_d = duo_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q    <= 2'b00;
      sample_q <= 8'h00;
    end else begin
      ack_q    <= gnt;
      sample_q <= sample_d;
    end
  end

`ifdef DUO_STEP_COUNT_EN
  logic [15:0] step_cnt_q, step_cnt_d;

  // Counted from step_en_d so the count moves in lockstep with the pulse.
  always_comb begin
    step_cnt_d = step_cnt_q;
    if (cmd == CMD_STOP)  step_cnt_d = 16'h0000;
    else if (step_en_d)   step_cnt_d = step_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_cnt_q <= 16'h0000;
    else        step_cnt_q <= step_cnt_d;
  end

  assign step_cnt = step_cnt_q;
`else
  assign step_cnt = 16'h0000;
`endif

  assign state   = state_q;
  assign step_en = step_en_q;
  assign ack     = ack_q;
  assign sample  = sample_q;

endmodule

// File: tb/tb_duo_color_ctrl.sv
// Self-checking bench for duo_color_ctrl: directed sequences, a command
// vector table and a scoreboard for the sample arbiter.
module tb_duo_color_ctrl;

  localparam int DIV_W = 24;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_we;
  logic [DIV_W-1:0] cfg_div;
  logic             cmd_stop, cmd_pause, cmd_run, cmd_step;
  logic [7:0]       duo_in;
  logic             step_en;
  logic [1:0]       req;
  logic [1:0]       ack;
  logic [7:0]       sample;
  logic [1:0]       state;
  logic [15:0]      step_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  duo_color_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_div   (cfg_div),
    .cmd_stop  (cmd_stop),
    .cmd_pause (cmd_pause),
    .cmd_run   (cmd_run),
    .cmd_step  (cmd_step),
    .duo_in    (duo_in),
    .step_en   (step_en),
    .req       (req),
    .ack       (ack),
    .sample    (sample),
    .state     (state),
    .step_cnt  (step_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cmds();
    cmd_stop = 1'b0; cmd_pause = 1'b0; cmd_run = 1'b0; cmd_step = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic do_cfg(input logic [DIV_W-1:0] d);
    cfg_we = 1'b1; cfg_div = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse(input logic s, input logic p, input logic r, input logic st);
    cmd_stop = s; cmd_pause = p; cmd_run = r; cmd_step = st;
    tick();
    clr_cmds();
  endtask

  // ---------------- arbiter scoreboard ----------------
  typedef struct packed {
    logic [1:0] ack;
    logic [7:0] sample;
  } exp_t;

  exp_t       sbq[$];
  logic       m_last;
  logic [1:0] m_ack;
  logic [7:0] m_sample;

  task automatic arb_cycle(input logic [1:0] r, input logic [7:0] d);
    logic [1:0] masked, g;
    exp_t e;
    req = r; duo_in = d;
    masked = r & ~m_ack;
    g = 2'b00;
    if (masked == 2'b11)      g = (m_last == 1'b0) ? 2'b10 : 2'b01;
    else if (masked == 2'b01) g = 2'b01;
    else if (masked == 2'b10) g = 2'b10;
    if (g != 2'b00) begin
      m_last   = g[1];
      m_sample = d;
    end
    m_ack = g;
    sbq.push_back({g, m_sample});
    tick();
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      chk("arb_ack", {30'd0, ack}, {30'd0, e.ack});
      chk("arb_sample", {24'd0, sample}, {24'd0, e.sample});
    end
    chk("ack_onehot0", {31'd0, ($countones(ack) <= 1)}, 32'd1);
  endtask

  // ---------------- command vector table ----------------
  typedef struct packed {
    logic       stop;
    logic       pause;
    logic       run;
    logic       step;
    logic [1:0] st;
    logic       sen;
  } vec_t;

  vec_t vt [12];

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [15:0] exp_cnt;

    vt[0]  = '{stop:0, pause:0, run:0, step:1, st:2'b00, sen:1};
    vt[1]  = '{stop:0, pause:0, run:0, step:0, st:2'b00, sen:0};
    vt[2]  = '{stop:0, pause:0, run:1, step:1, st:2'b01, sen:0};
    vt[3]  = '{stop:0, pause:0, run:0, step:1, st:2'b01, sen:0};
    vt[4]  = '{stop:0, pause:0, run:1, step:0, st:2'b01, sen:0};
    vt[5]  = '{stop:0, pause:1, run:1, step:0, st:2'b10, sen:0};
    vt[6]  = '{stop:0, pause:0, run:1, step:1, st:2'b01, sen:0};
    vt[7]  = '{stop:0, pause:1, run:0, step:1, st:2'b10, sen:0};
    vt[8]  = '{stop:0, pause:0, run:0, step:1, st:2'b10, sen:1};
    vt[9]  = '{stop:0, pause:0, run:0, step:0, st:2'b10, sen:0};
    vt[10] = '{stop:1, pause:1, run:1, step:1, st:2'b00, sen:0};
    vt[11] = '{stop:0, pause:1, run:0, step:0, st:2'b00, sen:0};

    rst_n = 1'b0; cfg_div = '0; duo_in = 8'h00; req = 2'b00;
    clr_cmds();
    m_last = 1'b1; m_ack = 2'b00; m_sample = 8'h00;
    repeat (3) tick();
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_step_en", {31'd0, step_en}, 32'd0);
    chk("rst_ack", {30'd0, ack}, 32'd0);
    chk("rst_sample", {24'd0, sample}, 32'd0);
    chk("rst_step_cnt", {16'd0, step_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Arbiter: both requesting continuously, first grant to requester 0.
    for (int i = 0; i < 8; i++) begin
      arb_cycle(2'b11, 8'h10 + 8'(i));
      chk("rr_alt", {30'd0, ack}, (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_sample", {24'd0, sample}, 32'h10 + 32'(i));
    end
    arb_cycle(2'b00, 8'hAA);
    arb_cycle(2'b00, 8'hBB);
    chk("sample_hold", {24'd0, sample}, 32'h17);
    for (int i = 0; i < 40; i++)
      arb_cycle(2'($urandom_range(0, 3)), 8'($urandom));
    arb_cycle(2'b00, 8'h00);
    arb_cycle(2'b00, 8'h00);

    // Period 3: one step every 4 cycles.
    do_cfg(24'd3);
    pulse(0, 0, 1, 0);
    chk("run_state", {30'd0, state}, 32'd1);
    chk("run_step0", {31'd0, step_en}, 32'd0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("p3_step", {31'd0, step_en}, (k % 4 == 0) ? 32'd1 : 32'd0);
    end
`ifdef DUO_STEP_COUNT_EN
    exp_cnt = 16'd5;
`else
    exp_cnt = 16'd0;
`endif
    chk("step_cnt20", {16'd0, step_cnt}, {16'd0, exp_cnt});
    pulse(1, 0, 0, 0);
    chk("stop_state", {30'd0, state}, 32'd0);
    chk("stop_cnt", {16'd0, step_cnt}, 32'd0);

    // cfg_we at terminal count: no step that edge, period restarts.
    pulse(0, 0, 1, 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("cfg_pre", {31'd0, step_en}, 32'd0);
    end
    do_cfg(24'd3);
    chk("cfg_no_step", {31'd0, step_en}, 32'd0);
    for (int k = 5; k <= 8; k++) begin
      tick();
      chk("cfg_post", {31'd0, step_en}, (k == 8) ? 32'd1 : 32'd0);
    end

    // Period 0 in RUN: step every cycle.
    do_cfg(24'd0);
    chk("p0_cfg_edge", {31'd0, step_en}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("p0_every", {31'd0, step_en}, 32'd1);
    end
    pulse(1, 0, 0, 0);
    chk("p0_stop_step", {31'd0, step_en}, 32'd0);
    chk("p0_stop_state", {30'd0, state}, 32'd0);

    // Period 9: pause at prescaler 6, resume, step 4 cycles later.
    do_cfg(24'd9);
    pulse(0, 0, 1, 0);
    repeat (6) tick();
    pulse(0, 1, 0, 0);
    chk("pause_state", {30'd0, state}, 32'd2);
    n = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (step_en) n++;
    end
    chk("pause_quiet", n, 32'd0);
    pulse(0, 0, 1, 0);
    chk("resume_state", {30'd0, state}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("resume_step", {31'd0, step_en}, (k == 4) ? 32'd1 : 32'd0);
    end

    // Three single steps while paused.
    pulse(0, 1, 0, 0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      pulse(0, 0, 0, 1);
      chk("pstep_hi", {31'd0, step_en}, 32'd1);
      if (step_en) n++;
      tick();
      chk("pstep_lo", {31'd0, step_en}, 32'd0);
      chk("pstep_state", {30'd0, state}, 32'd2);
    end
    chk("pstep_count", n, 32'd3);

    // stop and run together in RUN: stop wins.
    pulse(0, 0, 1, 0);
    chk("sr_pre", {30'd0, state}, 32'd1);
    pulse(1, 0, 1, 0);
    chk("sr_state", {30'd0, state}, 32'd0);
    n = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (step_en) n++;
    end
    chk("sr_quiet", n, 32'd0);
    chk("sr_cnt", {16'd0, step_cnt}, 32'd0);

    // Command priority table, long period so no periodic steps intrude.
    do_cfg(24'd100);
    for (int i = 0; i < 12; i++) begin
      pulse(vt[i].stop, vt[i].pause, vt[i].run, vt[i].step);
      chk($sformatf("vec%0d_state", i), {30'd0, state}, {30'd0, vt[i].st});
      chk($sformatf("vec%0d_step", i), {31'd0, step_en}, {31'd0, vt[i].sen});
    end

    // Async reset mid-RUN with ack and step_en high.
    do_cfg(24'd0);
    pulse(0, 0, 1, 0);
    req = 2'b11; duo_in = 8'h5A;
    tick();
    chk("pre_rst_ack", {31'd0, (ack != 2'b00)}, 32'd1);
    chk("pre_rst_step", {31'd0, step_en}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ack", {30'd0, ack}, 32'd0);
    chk("arst_step", {31'd0, step_en}, 32'd0);
    chk("arst_state", {30'd0, state}, 32'd0);
    chk("arst_sample", {24'd0, sample}, 32'd0);
    req = 2'b00;
    #2 rst_n = 1'b1;
    tick();
    pulse(0, 0, 1, 0);
    n = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (step_en) n++;
    end
    chk("def_div_quiet", n, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
